lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEMORY_SIZE, default 2048, data-memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(MEMORY_SIZE), word-index width driven to data_mem.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, memory request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load result.
REQ-013 SHALL have port resp_err, output, 1, request faulted; qualified by resp_valid.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, word index to data_mem.
REQ-015 SHALL have port mem_re, output, 1, data_mem read enable.
REQ-016 SHALL have port mem_we, output, 1, data_mem write enable.
REQ-017 SHALL have port mem_wdata, output, 32, data_mem write word.
REQ-018 SHALL have port mem_rdata, input, 32, data_mem read word; valid the cycle after mem_re.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CAP, WR, RESP, with one request outstanding at a time.
REQ-020 SHALL assert req_ready only in IDLE and only while rst is low.
REQ-021 SHALL latch req_we, req_funct3, req_addr and req_wdata on acceptance, then ignore the request inputs until the next IDLE.
REQ-022 SHALL drive mem_addr = latched addr[ADDR_WIDTH+1:2].
REQ-023 SHALL flag an error, and never touch memory, on any of:
  - addr[31:ADDR_WIDTH+2] nonzero;
  - halfword with addr[0]=1;
  - word with addr[1:0] nonzero;
  - an unlisted funct3.
REQ-024 SHALL transition IDLE on acceptance as follows:
  - error -> RESP;
  - load -> RD;
  - SW -> WR;
  - SB or SH -> RD (read-modify-write).
REQ-025 SHALL assert mem_re in RD only, then go to CAP.
REQ-026 SHALL capture mem_rdata in CAP; a load then goes to RESP, and SB/SH goes to WR.
REQ-027 SHALL extract loads by addr[1:0]:
  - LB/LH sign-extend bit 7/15 of the selected lane;
  - LBU/LHU zero-extend.
REQ-028 SHALL merge SB/SH by replacing only the addressed byte or halfword lane of the captured word with req_wdata[7:0] or [15:0]; SW writes req_wdata unchanged.
REQ-029 SHALL assert mem_we for exactly one cycle in WR with the merged word on mem_wdata, then go to RESP.
REQ-030 SHALL assert resp_valid for one cycle in RESP, then return to IDLE.
  - Stores and errors return resp_rdata = 0.
  - resp_err = 1 only for errored requests.
REQ-031 SHALL meet these latencies, with acceptance in cycle N:
  - error: resp_valid at N+1;
  - SW: mem_we at N+1, resp_valid at N+2;
  - loads: mem_re at N+1, resp_valid at N+3;
  - SB/SH: mem_re at N+1, mem_we at N+3, resp_valid at N+4.
REQ-032 SHALL hold mem_re, mem_we, resp_valid and resp_err at 0 outside their states, and never assert mem_re and mem_we together.
REQ-033 SHALL accept a new request in the cycle after resp_valid at the earliest.

Reset
REQ-034 SHALL, on a clock edge with rst high, enter IDLE and clear all latched fields and resp_rdata to 0.
REQ-035 SHALL, while rst is high, gate mem_re, mem_we and resp_valid to 0 in that same cycle.
  - A reset in any state, including WR, SHALL cause no memory write and no response.
REQ-036 SHALL drive all outputs to 0 after reset, except req_ready, which rises in the first cycle with rst low.

Structure
REQ-037 SHALL take the funct3 encodings and FSM state encodings from a shared rv32 defines header used by decode and lsu.
REQ-038 SHALL place lane extraction, extension and store merge in one combinational sub-module, lsu_align.

Verification
REQ-039 SHALL cover: preload word 0 = 0x8000_00F0; LB at addr 0x0 -> resp_rdata 0xFFFF_FFF0 at N+3; LBU -> 0x0000_00F0; LH at 0x2 -> 0xFFFF_8000.
REQ-040 SHALL cover: word 1 = 0x1122_3344; SB addr 0x5, wdata 0xAB -> one mem_we at N+3 with mem_wdata 0x1122_AB44; resp_valid at N+4.
REQ-041 SHALL cover: SW addr 0x1FFC (word 2047), wdata 0xDEAD_BEEF -> mem_addr 2047, mem_we at N+1; a following LW at 0x1FFC returns 0xDEAD_BEEF.
REQ-042 SHALL cover error cases, each -> resp_valid, resp_err = 1 at N+1, no mem_re or mem_we:
  - LW at addr 0x2;
  - SH at addr 0x1;
  - LW at addr 0x2000.
REQ-043 SHALL cover: SB in progress with rst high in the cycle the FSM is in WR -> mem_we stays 0, memory unchanged, req_ready = 1 in the cycle after rst falls.
REQ-044 SHALL cover: req_valid held high for back-to-back LW requests -> req_ready low from N+1 through N+3, next acceptance at N+4.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared RV32 definitions for the load/store unit: funct3 width codes and FSM state encoding.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte/halfword merge for
// read-modify-write stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [WORD_W-1:0] word,
  input  logic [15:0]       wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_sh   = {byte_off, 3'b000};
    half_sh   = {byte_off[1], 4'b0000};
    half_lane = byte_off[1] ? word[31:16] : word[15:0];
    case (byte_off)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = word;
    endcase

    // Only the addressed lane is replaced; the rest of the captured word is kept.
    case (funct3)
      F3_B:    merged = (word & ~(32'h0000_00FF << byte_sh)) | (32'(wdata[7:0]) << byte_sh);
      F3_H:    merged = (word & ~(32'h0000_FFFF << half_sh)) | (32'(wdata) << half_sh);
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: validates RV32I accesses, performs read-modify-write
// for sub-word stores and returns extended load data with a one-cycle response pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 2048,
  parameter int unsigned ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned BYTE_AW = ADDR_WIDTH + 2;

  lsu_state_e         state;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [BYTE_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic        range_err;
  logic        align_err;
  logic        f3_err;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Fault classification of the incoming request.
  always_comb begin
    range_err = (req_addr >> BYTE_AW) != 32'd0;
    align_err = 1'b0;
    f3_err    = 1'b0;
    case (req_funct3)
      F3_B:    f3_err = 1'b0;
      F3_BU:   f3_err = req_we;
      F3_H:    align_err = req_addr[0];
      F3_HU:   begin
        f3_err    = req_we;
        align_err = req_addr[0];
      end
      F3_W:    align_err = |req_addr[1:0];
      default: f3_err = 1'b1;
    endcase
    req_err = range_err | align_err | f3_err;
  end

  lsu_align u_align (
    .funct3    (funct3_q),
    .byte_off  (addr_q[1:0]),
    .word      (mem_rdata),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[BYTE_AW-1:0];
            wdata_q  <= req_wdata;
            rdata_q  <= 32'd0;
            err_q    <= req_err;
            if (req_err)                  state <= RESP;
            else if (!req_we)             state <= RD;
            else if (req_funct3 == F3_W)  state <= WR;
            else                          state <= RD;
          end
        end
        RD:   state <= CAP;
        CAP: begin
          if (we_q) begin
            wdata_q <= merged;
            state   <= WR;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WR:   state <= RESP;
        RESP: begin
          rdata_q <= 32'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a reset in any state suppresses writes and responses.
  assign req_ready  = (state == IDLE) && !rst;
  assign mem_re     = (state == RD)   && !rst;
  assign mem_we     = (state == WR)   && !rst;
  assign resp_valid = (state == RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q[BYTE_AW-1:2];
  assign mem_wdata  = wdata_q;

endmodule
